// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller for a small OLED display.
// Three modes: manual steering with the direction buttons, automatic bouncing,
// and pause. Positions only change on an update tick, which is derived from
// frame_begin divided down by FRAME_DIV, so the renderer never sees a
// mid-frame jump.
module sprite_motion_ctrl #(
   parameter int unsigned SCREEN_W  = 96,
   parameter int unsigned SCREEN_H  = 64,
   parameter int unsigned SPRITE_W  = 21,
   parameter int unsigned SPRITE_H  = 18,
   parameter int unsigned FRAME_DIV = 2,
   parameter int unsigned INIT_X    = 37,
   parameter int unsigned INIT_Y    = 23
) (
   input  logic       CLOCK,
   input  logic       RESET_N,
   input  logic       frame_begin,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnC,
   output logic [6:0] leftX,
   output logic [5:0] topY,
   output logic [1:0] mode,
   output logic       moved
);

   localparam logic [6:0] XMAX     = 7'(SCREEN_W - SPRITE_W);
   localparam logic [5:0] YMAX     = 6'(SCREEN_H - SPRITE_H);
   localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
   localparam logic [6:0] X_RESET  = 7'(INIT_X);
   localparam logic [5:0] Y_RESET  = 6'(INIT_Y);

   typedef enum logic [1:0] {
      StManual = 2'b00,
      StAuto   = 2'b01,
      StPause  = 2'b10
   } state_e;

   state_e     state_q, state_d;
   logic       btnc_q;
   logic       btnc_rise;
   logic [3:0] fcnt_q, fcnt_d;
   logic       tick;
   logic [6:0] x_q, x_d;
   logic [5:0] y_q, y_d;
   logic       dx_q, dx_d;   // 1 = moving right
   logic       dy_q, dy_d;   // 1 = moving down
   logic       moved_q, moved_d;

   assign btnc_rise = btnC & ~btnc_q;
   assign tick      = frame_begin && (fcnt_q == DIV_LAST);

   // Mode state register.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) state_q <= StManual;
      else          state_q <= state_d;
   end

   // Mode sequencing: each btnC press advances one step.
   always_comb begin
      state_d = state_q;
      if (btnc_rise) begin
         case (state_q)
            StManual: state_d = StAuto;
            StAuto:   state_d = StPause;
            default:  state_d = StManual;
         endcase
      end
   end

   // Mode output decode.
   always_comb begin
      mode = state_q;
   end

   // Frame divider: counts frame_begin pulses, wraps after FRAME_DIV of them.
   always_comb begin
      fcnt_d = fcnt_q;
      if (frame_begin) begin
         fcnt_d = (fcnt_q == DIV_LAST) ? 4'd0 : fcnt_q + 4'd1;
      end
   end

   // Position / direction next state; uses the pre-transition mode on a tick.
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      dx_d = dx_q;
      dy_d = dy_q;
      if (tick) begin
         case (state_q)
            StManual: begin
               if (btnR && !btnL && (x_q != XMAX))       x_d = x_q + 7'd1;
               else if (btnL && !btnR && (x_q != 7'd0))  x_d = x_q - 7'd1;
               if (btnD && !btnU && (y_q != YMAX))       y_d = y_q + 6'd1;
               else if (btnU && !btnD && (y_q != 6'd0))  y_d = y_q - 6'd1;
            end
            StAuto: begin
               if (dx_q) begin
                  if (x_q >= XMAX) begin
                     dx_d = 1'b0;
                     x_d  = XMAX - 7'd1;
                  end else begin
                     x_d  = x_q + 7'd1;
                  end
               end else begin
                  if (x_q == 7'd0) begin
                     dx_d = 1'b1;
                     x_d  = 7'd1;
                  end else begin
                     x_d  = x_q - 7'd1;
                  end
               end
               if (dy_q) begin
                  if (y_q >= YMAX) begin
                     dy_d = 1'b0;
                     y_d  = YMAX - 6'd1;
                  end else begin
                     y_d  = y_q + 6'd1;
                  end
               end else begin
                  if (y_q == 6'd0) begin
                     dy_d = 1'b1;
                     y_d  = 6'd1;
                  end else begin
                     y_d  = y_q - 6'd1;
                  end
               end
            end
            default: ;
         endcase
      end
      moved_d = (x_d != x_q) || (y_d != y_q);
   end

   // Datapath registers; reset wins over any coincident tick or btnC edge.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         btnc_q  <= 1'b0;
         fcnt_q  <= 4'd0;
         x_q     <= X_RESET;
         y_q     <= Y_RESET;
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
         moved_q <= 1'b0;
      end else begin
         btnc_q  <= btnC;
         fcnt_q  <= fcnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         moved_q <= moved_d;
      end
   end

   assign leftX = x_q;
   assign topY  = y_q;
   assign moved = moved_q;

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Parameters
REQ-001 The block SHALL expose parameter SCREEN_W, default 96, meaning OLED width in pixels.
REQ-002 The block SHALL expose parameter SCREEN_H, default 64, meaning OLED height in pixels.
REQ-003 The block SHALL expose parameter SPRITE_W, default 21, meaning sprite bounding-box width.
REQ-004 The block SHALL expose parameter SPRITE_H, default 18, meaning sprite bounding-box height.
REQ-005 The block SHALL expose parameter FRAME_DIV, default 2, meaning frames per position update (1..15).
REQ-006 The block SHALL expose parameters INIT_X, default 37, and INIT_Y, default 23, meaning reset position.

Interface
REQ-007 The block SHALL have a single clock and a synchronous, active-low reset: CLOCK and RESET_N.
REQ-008 CLOCK  input  1  system clock; all state updates on its rising edge.
REQ-009 RESET_N  input  1  synchronous active-low reset.
REQ-010 frame_begin  input  1  one-cycle pulse at start of each OLED frame.
REQ-011 btnL, btnR, btnU, btnD  input  1 each  debounced direction levels.
REQ-012 btnC  input  1  debounced mode-select level.
REQ-013 leftX  output  7  sprite left column for the sprite renderer.
REQ-014 topY  output  6  sprite top row for the sprite renderer.
REQ-015 mode  output  2  current state: 00 MANUAL, 01 AUTO, 10 PAUSE.
REQ-016 moved  output  1  one-cycle pulse when leftX or topY changed.

Function
REQ-017 XMAX SHALL be SCREEN_W-SPRITE_W (75) and YMAX SHALL be SCREEN_H-SPRITE_H (46); leftX in 0..XMAX, topY in 0..YMAX at all times.
REQ-018 FSM states MANUAL, AUTO, PAUSE; btnC rising edge (registered previous level, 0->1) SHALL advance MANUAL->AUTO->PAUSE->MANUAL in the next cycle; held btnC SHALL not re-advance.
REQ-019 A 4-bit frame counter SHALL increment on frame_begin and wrap to 0 after FRAME_DIV-1; update tick = frame_begin while counter == FRAME_DIV-1.
REQ-020 leftX/topY SHALL change only on the clock edge of an update tick, never mid-frame; latency tick -> new position = 1 cycle.
REQ-021 MANUAL: on tick, btnR alone -> leftX+1, btnL alone -> leftX-1, btnD alone -> topY+1, btnU alone -> topY-1; both L and R (or U and D) -> that axis unchanged.
REQ-022 MANUAL clamp: leftX at XMAX ignores btnR, at 0 ignores btnL; topY likewise against YMAX/0; no wrap-around.
REQ-023 AUTO: direction flags dx, dy (1 = +); on tick each axis moves 1 px in its direction.
REQ-024 AUTO bounce: if dx=+ and leftX==XMAX then dx<=- and leftX<=XMAX-1; if dx=- and leftX==0 then dx<=+ and leftX<=1; y axis identical against YMAX/0; both axes may bounce in one tick.
REQ-025 PAUSE: ticks SHALL leave position, dx, dy unchanged; frame counter keeps running.
REQ-026 Simultaneous btnC edge and tick: the position update SHALL use the state before the transition.
REQ-027 Entering AUTO SHALL keep the existing dx, dy; direction buttons SHALL be ignored in AUTO and PAUSE.
REQ-028 moved SHALL pulse 1 the cycle after a tick that changed leftX or topY, else 0.

Reset
REQ-029 On CLOCK edge with RESET_N=0, regardless of state: leftX=INIT_X (37), topY=INIT_Y (23), mode=MANUAL, dx=+, dy=+, frame counter=0, btnC history=0, moved=0.
REQ-030 Reset SHALL override any coincident tick or btnC edge; first tick after release uses FRAME_DIV full frames.

Verification
REQ-031 Reset, MANUAL, btnR held, 4 frame_begin pulses (FRAME_DIV=2) -> leftX 37->38->39 at ticks 2 and 4, topY=23, moved pulses twice.
REQ-032 MANUAL, leftX forced to 75 via 76 right ticks from 37 -> leftX stays 75 after 38th move, moved stays 0 on clamped ticks; btnL+btnR held -> no change.
REQ-033 btnC pulsed three times with long holds -> mode 00->01->10->00, each exactly one advance per press.
REQ-034 AUTO from (74,45) dx=+,dy=+ -> ticks give (75,46), then (74,45) with dx=-, dy=-, then (73,44).
REQ-035 PAUSE with 10 frames -> leftX/topY constant, moved=0; return to AUTO resumes prior direction.
REQ-036 RESET_N low for one cycle during AUTO at (60,10) coincident with a tick -> (37,23), mode=00, moved=0 next cycle.
